multicycle_controller: RTL and testbench
========================================

# multicycle_controller

Parametrised multi-cycle control FSM for the RV32I core: sequences fetch, decode, execute, memory and write-back, and drives the datapath load enables and the instruction/data memory handshake. New relative to the current controller: precise trap entry on illegal instructions, ECALL/EBREAK, misaligned accesses, memory error responses and memory timeout, plus optional external-interrupt acceptance. Sits between the instruction register, datapath and CSR file.

## Interface

Parameters:

- MEM_TIMEOUT, 16: cycles allowed in FETCH/MEMORY without memory_valid before an access fault; legal 1..255; 0 disables the timeout.
- CNT_W, 8: width of the timeout counter; must hold MEM_TIMEOUT.

Ports:

- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- instruction  in  32  current instruction register contents.
- memory_ready  in  1  memory can accept a request.
- memory_valid  in  1  memory response/completion this cycle.
- memory_error  in  1  qualifies memory_valid as an error response.
- address_misaligned  in  1  datapath flag, valid in EXECUTE: the load/store address or jump target is misaligned.
- irq_pending  in  1  external interrupt pending (level).
- irq_enable  in  1  mstatus.MIE from the CSR file.
- memory_enable  out  1  memory request strobe.
- memory_command  out  1  0 = read, 1 = write.
- instruction_write_enable  out  1  load instruction register.
- execute_result_write_enable  out  1  load execute-result register.
- load_memory_data_write_enable  out  1  load memory-data register.
- register_file_write_enable  out  1  write rd.
- pc_write_enable  out  1  update PC.
- pc_from_mtvec  out  1  PC source is mtvec (qualifies pc_write_enable).
- trap_save  out  1  CSR file captures mepc←PC, mcause, mtval.
- trap_interrupt  out  1  mcause[31].
- trap_cause  out  4  mcause[3:0].
- debug_state  out  3  current state encoding.

## Operation

- States and encodings: FETCH=0, DECODE=1, EXECUTE=2, MEMORY=3, WRITE_BACK=4, TRAP=5.
- FETCH: memory_enable=1 and memory_command=0 in every cycle with memory_ready=1 before the response. On memory_valid with memory_error=0: instruction_write_enable=1, go to DECODE. On memory_valid with memory_error=1: cause 1, go to TRAP.
- DECODE → EXECUTE unconditionally. Class decode happens here and is held in EXECUTE.
- EXECUTE: execute_result_write_enable=1. The next state is chosen in this order:
  - Illegal instruction (unknown opcode; shift funct7 other than 0000000/0100000; SYSTEM funct3 not in {000, 001, 010, 101}; SYSTEM funct3=000 other than ECALL/EBREAK/MRET): cause 2.
  - ECALL: cause 11. EBREAK: cause 3.
  - address_misaligned with LOAD: cause 4. With STORE: cause 6. With JAL/JALR: cause 0. Each goes to TRAP.
  - Otherwise LOAD/STORE → MEMORY; all other opcodes → WRITE_BACK.
- MEMORY: memory_command=0 for LOAD, 1 for STORE. memory_enable follows the same rule as in FETCH. On memory_valid: LOAD asserts load_memory_data_write_enable; go to WRITE_BACK. On memory_error: cause 5 (LOAD) or 7 (STORE), go to TRAP.
- WRITE_BACK: pc_write_enable=1. register_file_write_enable=1 for LUI, AUIPC, JAL, JALR, LOAD, OP-IMM, OP, and CSR ops. Next state FETCH.
- TRAP (1 cycle): trap_save=1, pc_write_enable=1, pc_from_mtvec=1, register_file_write_enable=0. Next state FETCH.
- Cause/interrupt bits are latched in a register when the trap is detected and presented on trap_cause/trap_interrupt. They hold until the next trap.
- Timeout: the counter clears on entry to FETCH/MEMORY and increments each cycle without memory_valid. A cycle where count == MEM_TIMEOUT−1 and memory_valid=0 is a timeout: cause 1 in FETCH, 5/7 in MEMORY. memory_valid in that same cycle wins over the timeout.
- A faulting instruction never writes the register file.

## Timing

- Reset (reset=0, asynchronous): state=FETCH, counter=0, trap_cause=0, trap_interrupt=0.
  - All strobes are 0 while reset is held. memory_command is 0.
  - Reset mid-access drops memory_enable in the same cycle.
- Normal latencies from FETCH completion: ALU ops 3 cycles to FETCH; loads/stores 3 + memory latency.
- Trap adds exactly one cycle (TRAP) before FETCH.
- Outputs other than the latched trap fields are combinational from state, instruction and memory inputs.

## Configuration

- CONTROLLER_IRQ_EN defined: in the first FETCH cycle (counter=0), irq_pending=1 with irq_enable=1 goes to TRAP, with trap_interrupt=1 and cause 11.
  - memory_enable=0 that cycle.
  - mepc receives the un-fetched PC.
- CONTROLLER_IRQ_EN undefined: irq_pending and irq_enable are ignored; the ports remain.

## Test plan

- ADDI x1,x0,5 with memory_valid 2 cycles after request → FETCH, DECODE, EXECUTE, WRITE_BACK with register_file_write_enable=1 in WRITE_BACK; debug_state sequence 0,0,0,1,2,4,0.
- Opcode 0x7F → TRAP after EXECUTE, trap_cause=2, trap_interrupt=0, trap_save=1, pc_from_mtvec=1, no register_file_write_enable.
- LW with memory_valid never asserted, MEM_TIMEOUT=4 → after 4 MEMORY cycles go to TRAP with cause 5. Repeat with memory_valid in the 4th cycle → WRITE_BACK, no trap.
- SW with address_misaligned=1 → TRAP with cause 6, zero MEMORY cycles. FETCH with memory_error=1 → cause 1.
- CONTROLLER_IRQ_EN, irq_pending=1, irq_enable=1 at FETCH entry → TRAP next cycle, trap_interrupt=1, cause 11, memory_enable never asserted. With irq_enable=0 → normal fetch.
- Deassert reset mid-MEMORY with memory_enable=1 → memory_enable=0 immediately, debug_state=0. After release the FSM restarts in FETCH.

Source files
------------

// File: rtl/multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_controller
// Description : Multi-cycle control FSM for the RV32I core. Sequences
//               FETCH -> DECODE -> EXECUTE -> [MEMORY] -> WRITE_BACK, drives
//               the datapath load enables and the instruction/data memory
//               handshake, and enters a one-cycle TRAP state on illegal
//               instructions, ECALL/EBREAK, misaligned accesses, memory error
//               responses and memory timeouts.
//
// Optional    : CONTROLLER_IRQ_EN - when defined, a pending and enabled
//               external interrupt is taken in the first FETCH cycle.
//               When undefined, irq_pending/irq_enable are ignored.
//
// Parameters  : MEM_TIMEOUT - cycles without memory_valid before an access
//                             fault (1..255, 0 disables the timeout)
//               CNT_W       - timeout counter width (must hold MEM_TIMEOUT)
//
// Ports       : clk, reset (async, active-low)
//               instruction                 - instruction register contents
//               memory_ready/valid/error    - memory handshake inputs
//               address_misaligned          - datapath flag, valid in EXECUTE
//               irq_pending, irq_enable     - external interrupt request/MIE
//               memory_enable/command       - memory request strobe, 1=write
//               *_write_enable              - datapath/regfile/PC load strobes
//               pc_from_mtvec, trap_save    - trap redirect and CSR capture
//               trap_interrupt, trap_cause  - latched mcause fields
//               debug_state                 - current state encoding
//
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_controller #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instruction,
    input  logic        memory_ready,
    input  logic        memory_valid,
    input  logic        memory_error,
    input  logic        address_misaligned,
    input  logic        irq_pending,
    input  logic        irq_enable,
    output logic        memory_enable,
    output logic        memory_command,
    output logic        instruction_write_enable,
    output logic        execute_result_write_enable,
    output logic        load_memory_data_write_enable,
    output logic        register_file_write_enable,
    output logic        pc_write_enable,
    output logic        pc_from_mtvec,
    output logic        trap_save,
    output logic        trap_interrupt,
    output logic [3:0]  trap_cause,
    output logic [2:0]  debug_state
);

    typedef enum logic [2:0] {
        S_FETCH      = 3'd0,
        S_DECODE     = 3'd1,
        S_EXECUTE    = 3'd2,
        S_MEMORY     = 3'd3,
        S_WRITE_BACK = 3'd4,
        S_TRAP       = 3'd5
    } state_t;

    localparam logic [6:0] c_op_lui    = 7'b0110111;
    localparam logic [6:0] c_op_auipc  = 7'b0010111;
    localparam logic [6:0] c_op_jal    = 7'b1101111;
    localparam logic [6:0] c_op_jalr   = 7'b1100111;
    localparam logic [6:0] c_op_branch = 7'b1100011;
    localparam logic [6:0] c_op_load   = 7'b0000011;
    localparam logic [6:0] c_op_store  = 7'b0100011;
    localparam logic [6:0] c_op_imm    = 7'b0010011;
    localparam logic [6:0] c_op_reg    = 7'b0110011;
    localparam logic [6:0] c_op_fence  = 7'b0001111;
    localparam logic [6:0] c_op_system = 7'b1110011;

    // instruction[31:7] of the three legal funct3=000 SYSTEM instructions
    localparam logic [24:0] c_ecall_hi  = 25'h0000000;
    localparam logic [24:0] c_ebreak_hi = 25'h0002000;
    localparam logic [24:0] c_mret_hi   = 25'h0604000;

    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(MEM_TIMEOUT - 1);

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_cnt;

    // Instruction class, captured in DECODE and held through the instruction
    logic r_illegal, r_ecall, r_ebreak, r_load, r_store, r_jump, r_rf_we;
    logic w_illegal, w_ecall, w_ebreak, w_load, w_store, w_jump, w_rf_we_cls;

    logic [3:0] r_trap_cause, w_cause;
    logic       r_trap_int, w_int;

    logic w_mem_en, w_mem_cmd, w_ir_we, w_ex_we, w_md_we, w_rf_we;
    logic w_pc_we, w_pc_mtvec, w_trap_save;

    logic w_resp_ok, w_resp_err, w_timeout, w_irq_take;

    // ------------------------------------------------------------------
    // Instruction class decode
    // ------------------------------------------------------------------
    logic [6:0] w_opcode;
    logic [2:0] w_funct3;
    logic [6:0] w_funct7;
    logic       w_known, w_shift_bad, w_sys_bad;

    assign w_opcode = instruction[6:0];
    assign w_funct3 = instruction[14:12];
    assign w_funct7 = instruction[31:25];

    always_comb begin
        w_known     = 1'b0;
        w_shift_bad = 1'b0;
        w_sys_bad   = 1'b0;
        w_ecall     = 1'b0;
        w_ebreak    = 1'b0;
        w_load      = (w_opcode == c_op_load);
        w_store     = (w_opcode == c_op_store);
        w_jump      = (w_opcode == c_op_jal) || (w_opcode == c_op_jalr);
        w_rf_we_cls = 1'b0;
        case (w_opcode)
            c_op_lui, c_op_auipc, c_op_jal, c_op_jalr, c_op_load: begin
                w_known     = 1'b1;
                w_rf_we_cls = 1'b1;
            end
            c_op_branch, c_op_store, c_op_fence: begin
                w_known = 1'b1;
            end
            c_op_imm, c_op_reg: begin
                w_known     = 1'b1;
                w_rf_we_cls = 1'b1;
                // Shifts only allow the logical/arithmetic funct7 encodings
                if ((w_funct3 == 3'b001) || (w_funct3 == 3'b101)) begin
                    w_shift_bad = (w_funct7 != 7'b0000000) && (w_funct7 != 7'b0100000);
                end
            end
            c_op_system: begin
                w_known = 1'b1;
                case (w_funct3)
                    3'b000: begin
                        w_ecall   = (instruction[31:7] == c_ecall_hi);
                        w_ebreak  = (instruction[31:7] == c_ebreak_hi);
                        w_sys_bad = !w_ecall && !w_ebreak && (instruction[31:7] != c_mret_hi);
                    end
                    3'b001, 3'b010, 3'b101: w_rf_we_cls = 1'b1;  // CSR ops
                    default: w_sys_bad = 1'b1;
                endcase
            end
            default: w_known = 1'b0;
        endcase
        w_illegal = !w_known || w_shift_bad || w_sys_bad;
    end

    // ------------------------------------------------------------------
    // Memory response qualification, timeout and interrupt acceptance
    // ------------------------------------------------------------------
    assign w_resp_ok  = memory_valid && !memory_error;
    assign w_resp_err = memory_valid && memory_error;
    // A response arriving in the final allowed cycle beats the timeout
    assign w_timeout  = (MEM_TIMEOUT != 0) && (r_cnt == c_cnt_last) && !memory_valid;

`ifdef CONTROLLER_IRQ_EN
    // Only the first FETCH cycle (counter still zero) may take an interrupt,
    // so no request has been issued and mepc is the un-fetched PC.
    assign w_irq_take = irq_pending && irq_enable && (r_cnt == '0);
`else
    logic w_unused_irq;
    assign w_irq_take   = 1'b0;
    assign w_unused_irq = irq_pending ^ irq_enable;
`endif

    // ------------------------------------------------------------------
    // Next state and strobes
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_cause      = r_trap_cause;
        w_int        = 1'b0;
        w_mem_en     = 1'b0;
        w_mem_cmd    = 1'b0;
        w_ir_we      = 1'b0;
        w_ex_we      = 1'b0;
        w_md_we      = 1'b0;
        w_rf_we      = 1'b0;
        w_pc_we      = 1'b0;
        w_pc_mtvec   = 1'b0;
        w_trap_save  = 1'b0;
        case (r_state)
            S_FETCH: begin
                if (w_irq_take) begin
                    w_state_next = S_TRAP;
                    w_cause      = 4'd11;
                    w_int        = 1'b1;
                end else begin
                    // Request strobe while the memory is ready, until the response
                    w_mem_en = memory_ready && !memory_valid;
                    if (w_resp_ok) begin
                        w_ir_we      = 1'b1;
                        w_state_next = S_DECODE;
                    end else if (w_resp_err || w_timeout) begin
                        w_state_next = S_TRAP;
                        w_cause      = 4'd1;
                    end
                end
            end
            S_DECODE: begin
                w_state_next = S_EXECUTE;
            end
            S_EXECUTE: begin
                w_ex_we = 1'b1;
                if (r_illegal) begin
                    w_state_next = S_TRAP;
                    w_cause      = 4'd2;
                end else if (r_ecall) begin
                    w_state_next = S_TRAP;
                    w_cause      = 4'd11;
                end else if (r_ebreak) begin
                    w_state_next = S_TRAP;
                    w_cause      = 4'd3;
                end else if (address_misaligned && r_load) begin
                    w_state_next = S_TRAP;
                    w_cause      = 4'd4;
                end else if (address_misaligned && r_store) begin
                    w_state_next = S_TRAP;
                    w_cause      = 4'd6;
                end else if (address_misaligned && r_jump) begin
                    w_state_next = S_TRAP;
                    w_cause      = 4'd0;
                end else if (r_load || r_store) begin
                    w_state_next = S_MEMORY;
                end else begin
                    w_state_next = S_WRITE_BACK;
                end
            end
            S_MEMORY: begin
                w_mem_cmd = r_store;
                w_mem_en  = memory_ready && !memory_valid;
                if (w_resp_ok) begin
                    w_md_we      = r_load;
                    w_state_next = S_WRITE_BACK;
                end else if (w_resp_err || w_timeout) begin
                    w_state_next = S_TRAP;
                    w_cause      = r_store ? 4'd7 : 4'd5;
                end
            end
            S_WRITE_BACK: begin
                w_pc_we      = 1'b1;
                w_rf_we      = r_rf_we;
                w_state_next = S_FETCH;
            end
            S_TRAP: begin
                w_trap_save  = 1'b1;
                w_pc_we      = 1'b1;
                w_pc_mtvec   = 1'b1;
                w_state_next = S_FETCH;
            end
            default: begin
                w_state_next = S_FETCH;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_FETCH;
            r_cnt        <= '0;
            r_trap_cause <= 4'd0;
            r_trap_int   <= 1'b0;
            r_illegal    <= 1'b0;
            r_ecall      <= 1'b0;
            r_ebreak     <= 1'b0;
            r_load       <= 1'b0;
            r_store      <= 1'b0;
            r_jump       <= 1'b0;
            r_rf_we      <= 1'b0;
        end else begin
            r_state <= w_state_next;

            // Any state change clears the counter, so it starts at zero on
            // entry to FETCH/MEMORY; it saturates so a disabled timeout
            // never wraps back to zero mid-fetch.
            if (w_state_next != r_state) begin
                r_cnt <= '0;
            end else if (!memory_valid && (r_cnt != '1)) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end

            if ((w_state_next == S_TRAP) && (r_state != S_TRAP)) begin
                r_trap_cause <= w_cause;
                r_trap_int   <= w_int;
            end

            if (r_state == S_DECODE) begin
                r_illegal <= w_illegal;
                r_ecall   <= w_ecall;
                r_ebreak  <= w_ebreak;
                r_load    <= w_load;
                r_store   <= w_store;
                r_jump    <= w_jump;
                r_rf_we   <= w_rf_we_cls;
            end
        end
    end

    // Strobes are forced low for as long as reset is held, including an
    // access that is cut off mid-cycle.
    assign memory_enable                 = w_mem_en    & reset;
    assign memory_command                = w_mem_cmd   & reset;
    assign instruction_write_enable      = w_ir_we     & reset;
    assign execute_result_write_enable   = w_ex_we     & reset;
    assign load_memory_data_write_enable = w_md_we     & reset;
    assign register_file_write_enable    = w_rf_we     & reset;
    assign pc_write_enable               = w_pc_we     & reset;
    assign pc_from_mtvec                 = w_pc_mtvec  & reset;
    assign trap_save                     = w_trap_save & reset;
    assign trap_interrupt                = r_trap_int;
    assign trap_cause                    = r_trap_cause;
    assign debug_state                   = r_state;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_controller
// Description : Self-checking bench for multicycle_controller. A behavioural
//               model classifies each instruction from the ISA rules and
//               predicts, cycle by cycle, the state and every strobe for a
//               chosen memory latency/error/misalignment scenario.
//               Directed scenarios are followed by randomized ones.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_controller;

    localparam int MEM_TIMEOUT = 4;
    localparam int CNT_W       = 8;
`ifdef CONTROLLER_IRQ_EN
    localparam bit IRQ_ON = 1'b1;
`else
    localparam bit IRQ_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instruction;
    logic        memory_ready, memory_valid, memory_error;
    logic        address_misaligned, irq_pending, irq_enable;
    logic        memory_enable, memory_command, instruction_write_enable;
    logic        execute_result_write_enable, load_memory_data_write_enable;
    logic        register_file_write_enable, pc_write_enable, pc_from_mtvec;
    logic        trap_save, trap_interrupt;
    logic [3:0]  trap_cause;
    logic [2:0]  debug_state;

    always #5 clk = ~clk;

    multicycle_controller #(
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .CNT_W       (CNT_W)
    ) dut (
        .clk                           (clk),
        .reset                         (reset),
        .instruction                   (instruction),
        .memory_ready                  (memory_ready),
        .memory_valid                  (memory_valid),
        .memory_error                  (memory_error),
        .address_misaligned            (address_misaligned),
        .irq_pending                   (irq_pending),
        .irq_enable                    (irq_enable),
        .memory_enable                 (memory_enable),
        .memory_command                (memory_command),
        .instruction_write_enable      (instruction_write_enable),
        .execute_result_write_enable   (execute_result_write_enable),
        .load_memory_data_write_enable (load_memory_data_write_enable),
        .register_file_write_enable    (register_file_write_enable),
        .pc_write_enable               (pc_write_enable),
        .pc_from_mtvec                 (pc_from_mtvec),
        .trap_save                     (trap_save),
        .trap_interrupt                (trap_interrupt),
        .trap_cause                    (trap_cause),
        .debug_state                   (debug_state)
    );

    int         vectors     = 0;
    int         miscompares = 0;
    logic [3:0] exp_cause   = 4'd0;
    logic       exp_int     = 1'b0;

    // {state, mem_en, mem_cmd, ir_we, ex_we, md_we, rf_we, pc_we, mtvec, trap_save}
    logic [11:0] obs_pk;
    assign obs_pk = {debug_state, memory_enable, memory_command, instruction_write_enable,
                     execute_result_write_enable, load_memory_data_write_enable,
                     register_file_write_enable, pc_write_enable, pc_from_mtvec, trap_save};

    function automatic logic [11:0] pk(input int st, input bit me, input bit mc, input bit iwe,
                                       input bit xwe, input bit lwe, input bit rwe, input bit pwe,
                                       input bit mtv, input bit ts);
        return {3'(st), me, mc, iwe, xwe, lwe, rwe, pwe, mtv, ts};
    endfunction

    function automatic bit rb();
        return bit'($urandom_range(0, 1));
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_fields();
        check("trap_fields", {27'd0, trap_interrupt, trap_cause}, {27'd0, exp_int, exp_cause});
    endtask

    task automatic drive(input bit r, input bit v, input bit e, input bit mis,
                         input bit ip, input bit ie);
        @(negedge clk);
        reset              = 1'b1;
        memory_ready       = r;
        memory_valid       = v;
        memory_error       = e;
        address_misaligned = mis;
        irq_pending        = ip;
        irq_enable         = ie;
        #1;
    endtask

    // ISA-level classification: exception cause raised in EXECUTE (-1 none)
    // and the instruction's memory/jump/rd-write properties.
    function automatic void classify(input logic [31:0] ins, output int xc, output bit ld,
                                     output bit st, output bit jp, output bit wr);
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        op = ins[6:0];
        f3 = ins[14:12];
        f7 = ins[31:25];
        xc = -1; ld = 0; st = 0; jp = 0; wr = 0;
        case (op)
            7'h37, 7'h17: wr = 1;
            7'h6f, 7'h67: begin wr = 1; jp = 1; end
            7'h63, 7'h0f: wr = 0;
            7'h03: begin ld = 1; wr = 1; end
            7'h23: st = 1;
            7'h13, 7'h33: begin
                wr = 1;
                if ((f3 == 3'd1 || f3 == 3'd5) && f7 != 7'h00 && f7 != 7'h20) xc = 2;
            end
            7'h73: begin
                if (f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd5) wr = 1;
                else if (f3 != 3'd0) xc = 2;
                else if (ins == 32'h00000073) xc = 11;
                else if (ins == 32'h00100073) xc = 3;
                else if (ins != 32'h30200073) xc = 2;
            end
            default: xc = 2;
        endcase
    endfunction

    function automatic logic [6:0] pick_f7();
        int k;
        k = $urandom_range(0, 2);
        if (k == 0) return 7'h00;
        if (k == 1) return 7'h20;
        return 7'($urandom);
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        w = $urandom;
        case ($urandom_range(0, 15))
            0:  w[6:0] = 7'h37;
            1:  w[6:0] = 7'h17;
            2:  w[6:0] = 7'h6f;
            3:  w[6:0] = 7'h67;
            4:  w[6:0] = 7'h63;
            5:  w[6:0] = 7'h03;
            6:  w[6:0] = 7'h23;
            7:  begin w[6:0] = 7'h13; w[31:25] = pick_f7(); end
            8:  begin w[6:0] = 7'h33; w[31:25] = pick_f7(); end
            9:  w[6:0] = 7'h0f;
            10: w = 32'h00000073;
            11: w = 32'h00100073;
            12: w = 32'h30200073;
            13: w[6:0] = 7'h73;
            default: w = w;
        endcase
        return w;
    endfunction

    // One instruction from its first FETCH cycle to its return to FETCH.
    // f_lat/m_lat: cycle (1-based) carrying memory_valid, 0 = never.
    // rst_at: MEMORY cycle in which reset is asserted, 0 = none.
    task automatic run_instr(input logic [31:0] ins, input int f_lat, input bit f_err,
                             input bit mis, input int m_lat, input bit m_err,
                             input bit irq_p, input bit irq_e, input int rst_at);
        int         c, xc;
        bit         r, v, fin, trap, intr, ld, st, jp, wr;
        logic [3:0] cause;
        instruction = ins;
        classify(ins, xc, ld, st, jp, wr);
        trap = 0; intr = 0; cause = 4'd0; fin = 0; c = 0;

        while (!fin) begin
            c++;
            r = rb();
            v = (c == f_lat);
            drive(r, v, v ? f_err : rb(), rb(), (c == 1) ? irq_p : rb(), (c == 1) ? irq_e : rb());
            if (IRQ_ON && c == 1 && irq_p && irq_e) begin
                check("fetch_irq", obs_pk, pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
                trap = 1; intr = 1; cause = 4'd11; fin = 1;
            end else begin
                check("fetch", obs_pk, pk(0, r && !v, 0, v && !f_err, 0, 0, 0, 0, 0, 0));
                if (v) begin
                    fin = 1; trap = f_err; cause = 4'd1;
                end else if (c == MEM_TIMEOUT) begin
                    fin = 1; trap = 1; cause = 4'd1;
                end
            end
            check_fields();
        end

        if (!trap) begin
            drive(rb(), rb(), rb(), rb(), rb(), rb());
            check("decode", obs_pk, pk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
            check_fields();
            drive(rb(), rb(), rb(), mis, rb(), rb());
            check("execute", obs_pk, pk(2, 0, 0, 0, 1, 0, 0, 0, 0, 0));
            check_fields();
            if (xc >= 0) begin
                trap = 1; cause = 4'(xc);
            end else if (mis && (ld || st || jp)) begin
                trap = 1; cause = ld ? 4'd4 : (st ? 4'd6 : 4'd0);
            end

            if (!trap && (ld || st)) begin
                fin = 0; c = 0;
                while (!fin) begin
                    c++;
                    r = (c == rst_at) ? 1'b1 : rb();
                    v = (c == m_lat);
                    drive(r, v, v ? m_err : rb(), rb(), rb(), rb());
                    check("memory", obs_pk, pk(3, r && !v, st, 0, 0, v && !m_err && ld, 0, 0, 0, 0));
                    check_fields();
                    if (c == rst_at) begin
                        reset = 1'b0;
                        #1;
                        check("reset_mid_memory", {28'd0, debug_state, memory_enable}, 32'd0);
                        check("reset_mid_strobes", obs_pk, pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
                        exp_cause = 4'd0;
                        exp_int   = 1'b0;
                        check_fields();
                        return;
                    end
                    if (v) begin
                        fin = 1; trap = m_err; cause = st ? 4'd7 : 4'd5;
                    end else if (c == MEM_TIMEOUT) begin
                        fin = 1; trap = 1; cause = st ? 4'd7 : 4'd5;
                    end
                end
            end

            if (!trap) begin
                drive(rb(), rb(), rb(), rb(), rb(), rb());
                check("write_back", obs_pk, pk(4, 0, 0, 0, 0, 0, wr, 1, 0, 0));
                check_fields();
            end
        end

        if (trap) begin
            drive(rb(), rb(), rb(), rb(), rb(), rb());
            exp_cause = cause;
            exp_int   = intr;
            check("trap", obs_pk, pk(5, 0, 0, 0, 0, 0, 0, 1, 1, 1));
            check_fields();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int f_lat, m_lat;
        reset              = 1'b0;
        instruction        = 32'h00000013;
        memory_ready       = 1'b1;
        memory_valid       = 1'b0;
        memory_error       = 1'b0;
        address_misaligned = 1'b0;
        irq_pending        = 1'b0;
        irq_enable         = 1'b0;

        // Reset held: FETCH, all strobes low even with memory ready
        @(negedge clk); #1;
        check("reset_strobes", obs_pk, pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        check_fields();
        memory_valid = 1'b1;
        @(negedge clk); #1;
        check("reset_strobes_valid", obs_pk, pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        // ADDI x1,x0,5 with response two cycles after the request
        run_instr(32'h00500093, 3, 0, 0, 0, 0, 0, 0, 0);
        // Unknown opcode 0x7F
        run_instr(32'h0000007f, 1, 0, 0, 0, 0, 0, 0, 0);
        // LW: memory timeout, then response in the last allowed cycle
        run_instr(32'h0000a103, 1, 0, 0, 0, 0, 0, 0, 0);
        run_instr(32'h0000a103, 2, 0, 0, 4, 0, 0, 0, 0);
        // SW misaligned, FETCH error response, FETCH timeout, SW error response
        run_instr(32'h0020a023, 1, 0, 1, 0, 0, 0, 0, 0);
        run_instr(32'h00500093, 2, 1, 0, 0, 0, 0, 0, 0);
        run_instr(32'h00500093, 0, 0, 0, 0, 0, 0, 0, 0);
        run_instr(32'h0020a023, 1, 0, 0, 2, 1, 0, 0, 0);
        // ECALL, EBREAK, MRET, JALR misaligned, CSRRW
        run_instr(32'h00000073, 1, 0, 0, 0, 0, 0, 0, 0);
        run_instr(32'h00100073, 1, 0, 0, 0, 0, 0, 0, 0);
        run_instr(32'h30200073, 1, 0, 0, 0, 0, 0, 0, 0);
        run_instr(32'h000080e7, 1, 0, 1, 0, 0, 0, 0, 0);
        run_instr(32'h34011073, 1, 0, 0, 0, 0, 0, 0, 0);
        // External interrupt at FETCH entry, then with MIE clear
        run_instr(32'h00500093, 2, 0, 0, 0, 0, 1, 1, 0);
        run_instr(32'h00500093, 2, 0, 0, 0, 0, 1, 0, 0);
        // Reset asserted mid-MEMORY, held one cycle, then a normal restart
        run_instr(32'h0000a103, 1, 0, 0, 0, 0, 0, 0, 2);
        @(negedge clk); #1;
        check("reset_hold", obs_pk, pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        run_instr(32'h00500093, 1, 0, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 150; i++) begin
            f_lat = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 5));
            m_lat = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 5));
            run_instr(rand_instr(), f_lat, ($urandom_range(0, 7) == 0),
                      ($urandom_range(0, 3) == 0), m_lat, ($urandom_range(0, 7) == 0),
                      rb(), rb(), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
